// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a simple load/store CPU.
// Steps T0..T7 through fetch, decode and execute. Every strobe is a
// combinational decode of the state register and the opcode, so reset
// clears all strobes without waiting for a clock edge.
//
// Ports:
//   clk, clr (async active-high reset), ir[31:0] (opcode in ir[31:27])
//   run, state[3:0]                                 status/debug
//   PCout PCIn IncPC                                program counter
//   MARIn MDRIn MDRout read write                   memory path
//   IRIn YIn ZIn Zlowout Zhighout HiIn LoIn         registers
//   Gra Grb Grc Rin Rout BAout Cout                 register select / constant
//   add subtract multiply divide                    ALU operation
//
// Build option: define MUL_DIV_EN to execute mul/div; without it they act
// as nop and multiply, divide, HiIn, LoIn and Zhighout stay 0.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  output logic        run,
  output logic [3:0]  state,
  output logic        PCout,
  output logic        PCIn,
  output logic        IncPC,
  output logic        MARIn,
  output logic        MDRIn,
  output logic        MDRout,
  output logic        read,
  output logic        write,
  output logic        IRIn,
  output logic        YIn,
  output logic        ZIn,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HiIn,
  output logic        LoIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        add,
  output logic        subtract,
  output logic        multiply,
  output logic        divide
);

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET = 4'b0000,
    S_T0    = 4'b0111,
    S_T1    = 4'b1000,
    S_T2    = 4'b1001,
    S_T3    = 4'b1010,
    S_T4    = 4'b1011,
    S_T5    = 4'b1100,
    S_T6    = 4'b1101,
    S_T7    = 4'b1110,
    S_HALT  = 4'b1111
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] opcode;
  logic            unused_ir_bits;

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];
  assign state          = state_q;

  // State register; clr aborts any instruction immediately
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Next-state: instruction length is decided by opcode at T2, T3, T5, T6
  always_comb begin
    state_d = S_RESET;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_ADDI, OP_LD, OP_ST, OP_JR: state_d = S_T3;
`ifdef MUL_DIV_EN
          OP_MUL, OP_DIV: state_d = S_T3;
`endif
          OP_HALT: state_d = S_HALT;
          default: state_d = S_T0;  // nop and undefined opcodes
        endcase
      end
      S_T3:    state_d = (opcode == OP_JR) ? S_T0 : S_T4;
      S_T4:    state_d = S_T5;
      S_T5: begin
        case (opcode)
          OP_LD, OP_ST: state_d = S_T6;
`ifdef MUL_DIV_EN
          OP_MUL, OP_DIV: state_d = S_T6;
`endif
          default: state_d = S_T0;
        endcase
      end
      S_T6:    state_d = (opcode == OP_LD || opcode == OP_ST) ? S_T7 : S_T0;
      S_T7:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Strobe decode; everything not named for a state stays 0
  always_comb begin
    run      = 1'b1;
    PCout    = 1'b0;
    PCIn     = 1'b0;
    IncPC    = 1'b0;
    MARIn    = 1'b0;
    MDRIn    = 1'b0;
    MDRout   = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    IRIn     = 1'b0;
    YIn      = 1'b0;
    ZIn      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HiIn     = 1'b0;
    LoIn     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    BAout    = 1'b0;
    Cout     = 1'b0;
    add      = 1'b0;
    subtract = 1'b0;
    multiply = 1'b0;
    divide   = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCIn = 1'b1; read = 1'b1; MDRIn = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRIn = 1'b1;
      end
      S_T3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_ADDI: begin
            Grb = 1'b1; Rout = 1'b1; YIn = 1'b1;
          end
          OP_LD, OP_ST: begin
            Grb = 1'b1; BAout = 1'b1; YIn = 1'b1;
          end
          OP_JR: begin
            Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1;
          end
`ifdef MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            Gra = 1'b1; Rout = 1'b1; YIn = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T4: begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            Grc = 1'b1; Rout = 1'b1; ZIn = 1'b1;
            add      = (opcode == OP_ADD);
            subtract = (opcode == OP_SUB);
          end
          OP_ADDI, OP_LD, OP_ST: begin
            Cout = 1'b1; add = 1'b1; ZIn = 1'b1;
          end
`ifdef MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            Grb = 1'b1; Rout = 1'b1; ZIn = 1'b1;
            multiply = (opcode == OP_MUL);
            divide   = (opcode == OP_DIV);
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_ADDI: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          OP_LD, OP_ST: begin
            Zlowout = 1'b1; MARIn = 1'b1;
          end
`ifdef MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            Zlowout = 1'b1; LoIn = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_LD: begin
            read = 1'b1; MDRIn = 1'b1;
          end
          OP_ST: begin
            Gra = 1'b1; Rout = 1'b1; MDRIn = 1'b1;
          end
`ifdef MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            Zhighout = 1'b1; HiIn = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          OP_ST: write = 1'b1;
          default: ;
        endcase
      end
      default: run = 1'b0;  // RESET, HALT and unused codes
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-vector bench for control_sequencer.
// Each cycle the state code, run and the packed strobe vector are compared
// against hand-written expectations at the falling clock edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        run;
  logic [3:0]  state;
  logic PCout, PCIn, IncPC, MARIn, MDRIn, MDRout, read, write, IRIn, YIn, ZIn;
  logic Zlowout, Zhighout, HiIn, LoIn, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic add, subtract, multiply, divide;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] S_RESET = 4'b0000, S_T0 = 4'b0111, S_T1 = 4'b1000,
                         S_T2 = 4'b1001, S_T3 = 4'b1010, S_T4 = 4'b1011,
                         S_T5 = 4'b1100, S_T6 = 4'b1101, S_T7 = 4'b1110,
                         S_HALT = 4'b1111;

  // Strobe bit masks, in the packing order of 'strobes' below
  localparam logic [25:0] M_PCOUT = 26'd1 << 25, M_PCIN = 26'd1 << 24,
    M_INCPC = 26'd1 << 23, M_MARIN = 26'd1 << 22, M_MDRIN = 26'd1 << 21,
    M_MDROUT = 26'd1 << 20, M_READ = 26'd1 << 19, M_WRITE = 26'd1 << 18,
    M_IRIN = 26'd1 << 17, M_YIN = 26'd1 << 16, M_ZIN = 26'd1 << 15,
    M_ZLO = 26'd1 << 14, M_ZHI = 26'd1 << 13, M_HIIN = 26'd1 << 12,
    M_LOIN = 26'd1 << 11, M_GRA = 26'd1 << 10, M_GRB = 26'd1 << 9,
    M_GRC = 26'd1 << 8, M_RIN = 26'd1 << 7, M_ROUT = 26'd1 << 6,
    M_BAOUT = 26'd1 << 5, M_COUT = 26'd1 << 4, M_ADD = 26'd1 << 3,
    M_SUB = 26'd1 << 2, M_MUL = 26'd1 << 1, M_DIV = 26'd1;

  localparam logic [25:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [25:0] E_T1 = M_ZLO | M_PCIN | M_READ | M_MDRIN;
  localparam logic [25:0] E_T2 = M_MDROUT | M_IRIN;

  logic [25:0] strobes;
  assign strobes = {PCout, PCIn, IncPC, MARIn, MDRIn, MDRout, read, write,
                    IRIn, YIn, ZIn, Zlowout, Zhighout, HiIn, LoIn, Gra, Grb,
                    Grc, Rin, Rout, BAout, Cout, add, subtract, multiply, divide};

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .run(run), .state(state),
    .PCout(PCout), .PCIn(PCIn), .IncPC(IncPC), .MARIn(MARIn), .MDRIn(MDRIn),
    .MDRout(MDRout), .read(read), .write(write), .IRIn(IRIn), .YIn(YIn),
    .ZIn(ZIn), .Zlowout(Zlowout), .Zhighout(Zhighout), .HiIn(HiIn),
    .LoIn(LoIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .add(add), .subtract(subtract),
    .multiply(multiply), .divide(divide)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare the present cycle, then move to the next falling edge
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [25:0] str);
    logic exp_run;
    exp_run = (st != S_RESET) && (st != S_HALT);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".strobes"}, 32'(strobes), 32'(str));
    check({tag, ".run"}, 32'(run), 32'(exp_run));
    @(negedge clk);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".T0"}, S_T0, E_T0);
    cyc({tag, ".T1"}, S_T1, E_T1);
    cyc({tag, ".T2"}, S_T2, E_T2);
  endtask

  initial begin
    clr = 1'b1;
    ir  = 32'h0;
    @(negedge clk);
    cyc("reset", S_RESET, 26'd0);

    // add r1,r2,r3
    ir  = 32'h18918000;
    clr = 1'b0;
    @(negedge clk);
    fetch("add");
    cyc("add.T3", S_T3, M_GRB | M_ROUT | M_YIN);
    cyc("add.T4", S_T4, M_GRC | M_ROUT | M_ZIN | M_ADD);
    cyc("add.T5", S_T5, M_ZLO | M_GRA | M_RIN);

    // jr r5
    ir = 32'h9A800000;
    fetch("jr");
    cyc("jr.T3", S_T3, M_GRA | M_ROUT | M_PCIN);

    // ld r1,0x10(r2)
    ir = 32'h00900010;
    fetch("ld");
    cyc("ld.T3", S_T3, M_GRB | M_BAOUT | M_YIN);
    cyc("ld.T4", S_T4, M_COUT | M_ADD | M_ZIN);
    cyc("ld.T5", S_T5, M_ZLO | M_MARIN);
    cyc("ld.T6", S_T6, M_READ | M_MDRIN);
    cyc("ld.T7", S_T7, M_MDROUT | M_GRA | M_RIN);

    // sub
    ir = 32'h21918000;
    fetch("sub");
    cyc("sub.T3", S_T3, M_GRB | M_ROUT | M_YIN);
    cyc("sub.T4", S_T4, M_GRC | M_ROUT | M_ZIN | M_SUB);
    cyc("sub.T5", S_T5, M_ZLO | M_GRA | M_RIN);

    // addi
    ir = 32'h58900005;
    fetch("addi");
    cyc("addi.T3", S_T3, M_GRB | M_ROUT | M_YIN);
    cyc("addi.T4", S_T4, M_COUT | M_ADD | M_ZIN);
    cyc("addi.T5", S_T5, M_ZLO | M_GRA | M_RIN);

    // nop and an undefined opcode both return after T2
    ir = 32'hC8000000;
    fetch("nop");
    ir = 32'hF8000000;
    fetch("undef");

    // mul and div
    ir = 32'h70918000;
    fetch("mul");
`ifdef MUL_DIV_EN
    cyc("mul.T3", S_T3, M_GRA | M_ROUT | M_YIN);
    cyc("mul.T4", S_T4, M_GRB | M_ROUT | M_ZIN | M_MUL);
    cyc("mul.T5", S_T5, M_ZLO | M_LOIN);
    cyc("mul.T6", S_T6, M_ZHI | M_HIIN);
`endif
    ir = 32'h78918000;
    fetch("div");
`ifdef MUL_DIV_EN
    cyc("div.T3", S_T3, M_GRA | M_ROUT | M_YIN);
    cyc("div.T4", S_T4, M_GRB | M_ROUT | M_ZIN | M_DIV);
    cyc("div.T5", S_T5, M_ZLO | M_LOIN);
    cyc("div.T6", S_T6, M_ZHI | M_HIIN);
`endif

    // st with clr raised in the middle of T7
    ir = 32'h10900010;
    fetch("st");
    cyc("st.T3", S_T3, M_GRB | M_BAOUT | M_YIN);
    cyc("st.T4", S_T4, M_COUT | M_ADD | M_ZIN);
    cyc("st.T5", S_T5, M_ZLO | M_MARIN);
    cyc("st.T6", S_T6, M_GRA | M_ROUT | M_MDRIN);
    check("st.T7.state", 32'(state), 32'(S_T7));
    check("st.T7.strobes", 32'(strobes), 32'(M_WRITE));
    #2 clr = 1'b1;
    #1;
    check("st.clr.write", 32'(write), 32'd0);
    check("st.clr.state", 32'(state), 32'(S_RESET));
    check("st.clr.strobes", 32'(strobes), 32'd0);
    @(negedge clk);
    cyc("st.clr.hold", S_RESET, 26'd0);
    clr = 1'b0;
    @(negedge clk);

    // halt, then hold for 20 clocks, then recover through clr
    ir = 32'hD0000000;
    fetch("halt");
    for (int i = 0; i < 21; i++) cyc("halt.hold", S_HALT, 26'd0);
    #2 clr = 1'b1;
    #1;
    check("halt.clr.state", 32'(state), 32'(S_RESET));
    check("halt.clr.run", 32'(run), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    ir  = 32'hC8000000;
    @(negedge clk);
    cyc("halt.restart.T0", S_T0, E_T0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have a port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have a port clr, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have a port ir, input, 32 bits: the instruction register contents; opcode is ir[31:27].
REQ-004 The block SHALL have a port run, output, 1 bit: high while sequencing, low in RESET and HALT.
REQ-005 The block SHALL have a port state, output, 4 bits: present-state code, for debug.
REQ-006 The block SHALL have outputs PCout, PCIn, IncPC, 1 bit each: program-counter strobes.
REQ-007 The block SHALL have outputs MARIn, MDRIn, MDRout, read, write, 1 bit each: memory-path strobes.
REQ-008 The block SHALL have outputs IRIn, YIn, ZIn, Zlowout, Zhighout, HiIn, LoIn, 1 bit each: register strobes.
REQ-009 The block SHALL have outputs Gra, Grb, Grc, Rin, Rout, BAout, Cout, 1 bit each: register-select and constant strobes.
REQ-010 The block SHALL have outputs add, subtract, multiply, divide, 1 bit each: ALU operation selects.

Function
REQ-011 Opcodes SHALL be: ld 00000, st 00010, add 00011, sub 00100, addi 01011, mul 01110, div 01111, jr 10011, nop 11001, halt 11010.
REQ-012 The states SHALL be RESET 0000, T0 0111, T1 1000, T2 1001, T3 1010, T4 1011, T5 1100, T6 1101, T7 1110, HALT 1111; one state per clock.
REQ-013 All outputs SHALL be combinational functions of the state register and ir[31:27] only; any strobe not listed for a state SHALL be 0.
REQ-014 T0 SHALL assert PCout, MARIn, IncPC and ZIn.
REQ-015 T1 SHALL assert Zlowout, PCIn, read and MDRIn.
REQ-016 T2 SHALL assert MDRout and IRIn.
REQ-017 Decode SHALL take place in T2 on the loaded ir value; T3 onward SHALL use ir held stable by the datapath.
REQ-018 For add/sub: T3 SHALL assert Grb, Rout, YIn; T4 SHALL assert Grc, Rout, ZIn and add or subtract; T5 SHALL assert Zlowout, Gra, Rin; then T0.
REQ-019 For addi: T3 SHALL assert Grb, Rout, YIn; T4 SHALL assert Cout, add, ZIn; T5 SHALL assert Zlowout, Gra, Rin; then T0.
REQ-020 For ld: T3 SHALL assert Grb, BAout, YIn; T4 SHALL assert Cout, add, ZIn; T5 SHALL assert Zlowout, MARIn; T6 SHALL assert read, MDRIn; T7 SHALL assert MDRout, Gra, Rin; then T0.
REQ-021 For st: T3 through T5 SHALL be as for ld; T6 SHALL assert Gra, Rout, MDRIn; T7 SHALL assert write; then T0.
REQ-022 For jr: T3 SHALL assert Gra, Rout, PCIn; then T0.
REQ-023 For nop and any undefined opcode: T2 SHALL transition directly to T0.
REQ-024 For halt: T2 SHALL transition to HALT; HALT SHALL hold, with all strobes 0 and run=0, until clr.
REQ-025 read and write SHALL never be asserted in the same state.
REQ-026 Instruction latencies SHALL be: nop 3, jr 4, add/sub/addi 6, ld/st 8 cycles, each measured from entry into T0.

Reset
REQ-027 clr=1 SHALL force the state to RESET immediately, regardless of clk, aborting any instruction in progress.
REQ-028 In RESET, all strobes and run SHALL be 0 and state SHALL be 0000; a write in T7 SHALL drop the same instant clr rises.
REQ-029 The first rising clk edge with clr=0 SHALL move the state from RESET to T0.

Configuration
REQ-030 With macro MUL_DIV_EN defined, mul/div SHALL run four execute states:
- T3: Gra, Rout, YIn
- T4: Grb, Rout, ZIn, and multiply or divide
- T5: Zlowout, LoIn
- T6: Zhighout, HiIn
- then T0; latency 7 cycles
REQ-031 Without MUL_DIV_EN, mul/div SHALL behave as nop, and multiply, divide, HiIn, LoIn and Zhighout SHALL be constant 0.

Verification
REQ-032 clr pulse, then ir=0x18918000 (add r1,r2,r3) -> states run T0..T5: T4 shows Grc, Rout, add, ZIn; T5 shows Gra, Rin; return to T0 after 6 cycles.
REQ-033 ir=0x9A800000 (jr r5) -> T3 asserts Gra, Rout, PCIn together; T0 follows on the next edge.
REQ-034 ir=0x00900010 (ld r1,0x10(r2)) -> T6 asserts read with MDRIn; T7 asserts MDRout, Gra, Rin; write stays 0 throughout.
REQ-035 ir=0xD0000000 (halt) -> HALT (1111) from the cycle after T2; run=0 for 20 further clocks; clr returns to RESET, then T0.
REQ-036 st ir=0x10900010 with clr asserted mid-T7 -> write falls without waiting for a clk edge; state=0000.
REQ-037 ir=0x70918000 (mul) -> with MUL_DIV_EN: LoIn in T5, HiIn in T6; without it: T2 goes to T0 and multiply never rises.
